// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
// Holds the controller state encoding, a ceil-log2 helper, the default
// geometry and the line layout {valid, dirty, tag, data}.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    RESP,
    FLUSH
  } state_t;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Default geometry: 8-bit word address and data, 4 sets, 2 ways.
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SETS   = 4;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_IDX_W  = clog2(DEF_SETS);
  localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W;

  // Line layout at the default geometry; the top re-declares the same
  // layout sized by its own parameters.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracker: one age per (set, way). Age 0 is the most recently
// touched way, age WAYS-1 the least recently touched one (the victim).
module cache_lru
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS,
  localparam int IDX_W = clog2(SETS),
  localparam int AGE_W = clog2(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [AGE_W-1:0] touch_way,
  input  logic             update,
  output logic [AGE_W-1:0] victim
);

  logic [AGE_W-1:0] ages [SETS][WAYS];

  // Victim of the addressed set is the way carrying the oldest age.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[set_idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
  end

  // Touched way becomes youngest; every way younger than it ages by one,
  // so the ages of a set stay a permutation of 0..WAYS-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ages[s][w] <= AGE_W'(w);
        end
      end
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == touch_way) begin
          ages[set_idx][w] <= '0;
        end else if (ages[set_idx][w] < ages[set_idx][touch_way]) begin
          ages[set_idx][w] <= ages[set_idx][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative, write-back, write-allocate cache, one word per line.
// Sits between a CPU load/store port and a single-port RAM, both using
// valid/ready style handshakes. Victims follow true LRU per set.
// Optional feature: define CACHE_FLUSH_EN to add flush_req/flush_done, which
// write back every dirty line in (set, way) order and leave it clean.
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SETS   = DEF_SETS,
  parameter int WAYS   = DEF_WAYS,
  localparam int IDX_W = clog2(SETS),
  localparam int TAG_W = ADDR_W - IDX_W,
  localparam int AGE_W = clog2(WAYS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_FLUSH_EN
  ,
  input  logic              flush_req,
  output logic              flush_done
`endif
);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

  state_t            state, next_state;
  logic              req_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [AGE_W-1:0]  victim_q;
  logic [DATA_W-1:0] resp_data_q;

  cache_line_t       lines [SETS][WAYS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_q;
  logic [AGE_W-1:0]  wb_way;
  cache_line_t       wb_line;
  logic              hit;
  logic [AGE_W-1:0]  hit_way;
  logic [AGE_W-1:0]  lru_victim;
  logic [AGE_W-1:0]  miss_victim;
  logic              lru_update;
  logic [AGE_W-1:0]  lru_way;

`ifdef CACHE_FLUSH_EN
  logic              flush_active;
  logic [IDX_W-1:0]  flush_set;
  logic [AGE_W-1:0]  flush_way;
  logic              flush_last;
  logic              flush_step;

  assign idx    = flush_active ? flush_set : addr_q[IDX_W-1:0];
  assign wb_way = flush_active ? flush_way : victim_q;
`else
  assign idx    = addr_q[IDX_W-1:0];
  assign wb_way = victim_q;
`endif

  assign tag_q   = addr_q[ADDR_W-1:IDX_W];
  assign wb_line = lines[idx][wb_way];

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clock     (clock),
    .reset     (reset),
    .set_idx   (idx),
    .touch_way (lru_way),
    .update    (lru_update),
    .victim    (lru_victim)
  );

  // Tag match across the set, and miss victim: lowest invalid way, else LRU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit         = 1'b0;
    hit_way     = '0;
    miss_victim = lru_victim;
    for (int w = 0; w < WAYS; w++) begin
      if (lines[idx][w].valid && lines[idx][w].tag == tag_q) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!lines[idx][w].valid) miss_victim = AGE_W'(w);
    end
  end

`ifdef CACHE_FLUSH_EN
  // Flush walk: advance past a clean/invalid line, or after its writeback.
  always_comb begin
    flush_last = (flush_set == IDX_W'(SETS - 1)) && (flush_way == AGE_W'(WAYS - 1));
    flush_step = ((state == FLUSH) && !(wb_line.valid && wb_line.dirty)) ||
                 ((state == WRITEBACK) && mem_ready && flush_active);
  end
`endif

  // Controller next state and all handshake / RAM outputs.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    lru_update = 1'b0;
    lru_way    = victim_q;
    case (state)
      IDLE: begin
`ifdef CACHE_FLUSH_EN
        req_ready = !flush_req;
        if (flush_req) next_state = FLUSH;
        else if (req_valid) next_state = LOOKUP;
`else
        req_ready = 1'b1;
        if (req_valid) next_state = LOOKUP;
`endif
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = req_we_q ? wdata_q : lines[idx][hit_way].data;
          lru_update = 1'b1;
          lru_way    = hit_way;
          next_state = IDLE;
        end else if (lines[idx][miss_victim].valid && lines[idx][miss_victim].dirty) begin
          next_state = WRITEBACK;
        end else begin
          next_state = FILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_line.tag, idx};
        mem_wdata = wb_line.data;
        if (mem_ready) begin
`ifdef CACHE_FLUSH_EN
          if (flush_active) next_state = flush_last ? IDLE : FLUSH;
          else next_state = FILL;
`else
          next_state = FILL;
`endif
        end
      end
      FILL: begin
        if (req_we_q) begin
          lru_update = 1'b1;
          next_state = RESP;
        end else begin
          mem_req  = 1'b1;
          mem_addr = addr_q;
          if (mem_ready) begin
            lru_update = 1'b1;
            next_state = RESP;
          end
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = resp_data_q;
        next_state = IDLE;
      end
`ifdef CACHE_FLUSH_EN
      FLUSH: begin
        if (wb_line.valid && wb_line.dirty) next_state = WRITEBACK;
        else if (flush_last) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // State register and request capture.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      req_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      victim_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_valid && req_ready) begin
        req_we_q <= req_we;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == LOOKUP && !hit) victim_q <= miss_victim;
      if (state == FILL && lru_update) resp_data_q <= req_we_q ? wdata_q : mem_rdata;
    end
  end

  // Line storage: store hits, installs, and dirty clearing during flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: only valid/dirty are reset; tag and data are don't-care while invalid.
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          lines[s][w].valid <= 1'b0;
          lines[s][w].dirty <= 1'b0;
        end
      end
    end else begin
      if (state == LOOKUP && hit && req_we_q) begin
        lines[idx][hit_way].data  <= wdata_q;
        lines[idx][hit_way].dirty <= 1'b1;
      end
      if (state == FILL && lru_update) begin
        lines[idx][victim_q].valid <= 1'b1;
        lines[idx][victim_q].dirty <= req_we_q;
        lines[idx][victim_q].tag   <= tag_q;
        lines[idx][victim_q].data  <= req_we_q ? wdata_q : mem_rdata;
      end
`ifdef CACHE_FLUSH_EN
      if (state == WRITEBACK && mem_ready && flush_active) begin
        lines[flush_set][flush_way].dirty <= 1'b0;
      end
`endif
    end
  end

`ifdef CACHE_FLUSH_EN
  // Flush pointer and completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_active <= 1'b0;
      flush_set    <= '0;
      flush_way    <= '0;
      flush_done   <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (state == IDLE && flush_req) begin
        flush_active <= 1'b1;
        flush_set    <= '0;
        flush_way    <= '0;
      end else if (flush_step) begin
        if (flush_last) begin
          flush_active <= 1'b0;
          flush_done   <= 1'b1;
        end else begin
          {flush_set, flush_way} <= {flush_set, flush_way} + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb at the default geometry (4 sets, 2 ways,
// 8-bit). A small RAM responder with programmable ready delay logs every
// writeback; the flush sequence runs only when CACHE_FLUSH_EN is defined.
module tb_cache_sa_wb;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ready;
  logic [7:0] mem_rdata;
`ifdef CACHE_FLUSH_EN
  logic       flush_req = 1'b0;
  logic       flush_done;
`endif

  cache_sa_wb dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
`ifdef CACHE_FLUSH_EN
    ,
    .flush_req  (flush_req),
    .flush_done (flush_done)
`endif
  );

  initial forever #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model and access log.
  logic [7:0] ram [256];
  int         mem_delay = 0;
  int         wait_cnt  = 0;
  int         wb_n      = 0;
  int         rd_n      = 0;
  logic [7:0] wb_addr [16];
  logic [7:0] wb_data [16];
  logic [7:0] last_rd_addr = '0;

  // Responder: decides mem_ready for the coming edge, 2 time units after each edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      mem_ready = 1'b0;
      if (mem_req && !reset) begin
        if (wait_cnt >= mem_delay) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            if (wb_n < 16) begin
              wb_addr[wb_n] = mem_addr;
              wb_data[wb_n] = mem_wdata;
            end
            wb_n++;
          end else begin
            mem_rdata    = ram[mem_addr];
            last_rd_addr = mem_addr;
            rd_n++;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One CPU transaction; returns the response word and cycles from acceptance to resp_valid.
  task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
    int guard;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!req_ready) check({tag, " ready timeout"}, 32'd0, 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!resp_valid) check({tag, " resp timeout"}, 32'd0, 32'd1);
    rdata = resp_rdata;
    step();
  endtask

  task automatic access_chk(input string tag, input logic we, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_data, input int exp_lat);
    logic [7:0] rdata;
    int         lat;
    do_req(tag, we, addr, wdata, rdata, lat);
    check({tag, " data"}, 32'(rdata), 32'(exp_data));
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int wb0;
    int rd0;
    int guard;
    logic [7:0] rdata;
    int         lat;
    logic ok_stable;

    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[8'h05] = 8'hA5;
    ram[8'h09] = 8'h99;
    ram[8'h0D] = 8'hD7;
    ram[8'h06] = 8'h11;
    ram[8'h02] = 8'h22;

    // Reset state.
    do_reset();
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset resp_rdata", 32'(resp_rdata), 32'd0);

    // Clean load miss, then the same load hits with latency 1.
    rd0 = rd_n;
    access_chk("ld05 miss", 1'b0, 8'h05, 8'h00, 8'hA5, 3);
    check("ld05 refill count", 32'(rd_n - rd0), 32'd1);
    check("ld05 refill addr", 32'(last_rd_addr), 32'h05);
    check("ld05 mem_req dropped", 32'(mem_req), 32'd0);
    rd0 = rd_n;
    access_chk("ld05 hit", 1'b0, 8'h05, 8'h00, 8'hA5, 1);
    check("ld05 hit no ram", 32'(rd_n - rd0), 32'd0);

    // Store miss into invalid way, store hit, then dirty LRU victim writeback.
    wb0 = wb_n;
    access_chk("st01 miss", 1'b1, 8'h01, 8'h3C, 8'h3C, 3);
    access_chk("st05 hit", 1'b1, 8'h05, 8'h4D, 8'h4D, 1);
    check("stores no writeback", 32'(wb_n - wb0), 32'd0);
    access_chk("ld09 dirty miss", 1'b0, 8'h09, 8'h00, 8'h99, 4);
    check("ld09 wb count", 32'(wb_n - wb0), 32'd1);
    check("ld09 wb addr", 32'(wb_addr[wb0]), 32'h01);
    check("ld09 wb data", 32'(wb_data[wb0]), 32'h3C);

    // Same pattern with a hit on 0x01 first: the victim moves to 0x05.
    do_reset();
    access_chk("r ld05", 1'b0, 8'h05, 8'h00, 8'hA5, 3);
    access_chk("r st01", 1'b1, 8'h01, 8'h3C, 8'h3C, 3);
    access_chk("r st05", 1'b1, 8'h05, 8'h4D, 8'h4D, 1);
    access_chk("r ld01 hit", 1'b0, 8'h01, 8'h00, 8'h3C, 1);
    wb0 = wb_n;
    access_chk("r ld09 miss", 1'b0, 8'h09, 8'h00, 8'h99, 4);
    check("r ld09 wb count", 32'(wb_n - wb0), 32'd1);
    check("r ld09 wb addr", 32'(wb_addr[wb0]), 32'h05);
    check("r ld09 wb data", 32'(wb_data[wb0]), 32'h4D);

    // Slow RAM during writeback of dirty 0x01 (set 1 LRU): outputs hold, no acceptance.
    mem_delay = 5;
    wb0 = wb_n;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h0D;
    req_wdata = 8'h00;
    step();
    req_valid = 1'b0;
    step();
    check("slow wb mem_req", 32'(mem_req), 32'd1);
    check("slow wb mem_we", 32'(mem_we), 32'd1);
    check("slow wb mem_addr", 32'(mem_addr), 32'h01);
    check("slow wb mem_wdata", 32'(mem_wdata), 32'h3C);
    ok_stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h09;
      if (req_ready !== 1'b0) ok_stable = 1'b0;
      step();
      req_valid = 1'b0;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h01 ||
          mem_wdata !== 8'h3C || resp_valid !== 1'b0) ok_stable = 1'b0;
    end
    check("slow wb held stable", 32'(ok_stable), 32'd1);
    lat = 0;
    while (!resp_valid && lat < 60) begin
      step();
      lat++;
    end
    check("slow ld0D resp seen", 32'(resp_valid), 32'd1);
    check("slow ld0D data", 32'(resp_rdata), 32'hD7);
    check("slow wb count", 32'(wb_n - wb0), 32'd1);
    step();
    ok_stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) ok_stable = 1'b0;
      step();
    end
    check("slow no extra resp", 32'(ok_stable), 32'd1);

    // Reset while a refill is outstanding.
    access_chk("st06", 1'b1, 8'h06, 8'h66, 8'h66, 3);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h0A;
    step();
    req_valid = 1'b0;
    step();
    check("fill mem_req", 32'(mem_req), 32'd1);
    check("fill mem_addr", 32'(mem_addr), 32'h0A);
    reset = 1'b1;
    step();
    check("reset mid fill mem_req", 32'(mem_req), 32'd0);
    check("reset mid fill resp", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    mem_delay = 0;
    ok_stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0) ok_stable = 1'b0;
      step();
    end
    check("no resp after reset", 32'(ok_stable), 32'd1);
    access_chk("ld06 misses after reset", 1'b0, 8'h06, 8'h00, 8'h11, 3);

`ifdef CACHE_FLUSH_EN
    // Flush three dirty lines in set/way order; they then hit clean.
    do_reset();
    access_chk("f st00", 1'b1, 8'h00, 8'h10, 8'h10, 3);
    access_chk("f st04", 1'b1, 8'h04, 8'h14, 8'h14, 3);
    access_chk("f st07", 1'b1, 8'h07, 8'h17, 8'h17, 3);
    access_chk("f ld02", 1'b0, 8'h02, 8'h00, 8'h22, 3);
    wb0 = wb_n;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("flush req_ready low", 32'(req_ready), 32'd0);
    guard = 0;
    while (!flush_done && guard < 200) begin
      step();
      guard++;
    end
    check("flush_done seen", 32'(flush_done), 32'd1);
    check("flush wb count", 32'(wb_n - wb0), 32'd3);
    check("flush wb0 addr", 32'(wb_addr[wb0]), 32'h00);
    check("flush wb0 data", 32'(wb_data[wb0]), 32'h10);
    check("flush wb1 addr", 32'(wb_addr[wb0 + 1]), 32'h04);
    check("flush wb2 addr", 32'(wb_addr[wb0 + 2]), 32'h07);
    check("flush wb2 data", 32'(wb_data[wb0 + 2]), 32'h17);
    step();
    check("flush_done pulse", 32'(flush_done), 32'd0);
    wb0 = wb_n;
    access_chk("f ld00 hit", 1'b0, 8'h00, 8'h00, 8'h10, 1);
    access_chk("f ld04 hit", 1'b0, 8'h04, 8'h00, 8'h14, 1);
    access_chk("f ld07 hit", 1'b0, 8'h07, 8'h00, 8'h17, 1);
    access_chk("f ld08 clean evict", 1'b0, 8'h08, 8'h00, 8'h08, 3);
    check("f no wb after flush", 32'(wb_n - wb0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
